femto_tick_gen: RTL and testbench

//  Fractional-N clock-enable generator, the downstream counterpart of femtoPLL.

---
 rtl/femto_tick_gen.sv | 116 +++++++++++
 tb/tb_femto_tick_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/femto_tick_gen.sv
// femto_tick_gen: fractional-N clock-enable generator.
// A phase accumulator advances by inc_r every enabled cycle. Each wrap gives a
// one-cycle tick, and the accumulator MSB gives a ~50% square wave.
// New increments arrive over a valid/ready handshake. They are held pending
// and applied at a wrap, while frozen, or while stopped, so that rate changes
// stay on the tick grid.
module femto_tick_gen #(
    parameter int          ACC_W     = 24,
    parameter int          CNT_W     = 32,
    parameter int unsigned INC_RESET = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [ACC_W-1:0] cfg_inc,
    output logic             cfg_ready,
    output logic             tick,
    output logic             sq,
    output logic [CNT_W-1:0] tick_cnt
);

    typedef enum logic {
        CFG_IDLE,
        CFG_PEND
    } cfg_state_t;

    cfg_state_t       state;
    cfg_state_t       state_nxt;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc_r;
    logic [ACC_W-1:0] pend_inc;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             pend;
    logic             xfer;
    logic             apply;

    // Widened add: the extra top bit is the wrap (carry) indicator.
    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    assign sum       = acc_add(acc, inc_r);
    assign carry     = sum[ACC_W];
    assign pend      = (state == CFG_PEND);
    assign cfg_ready = (state == CFG_IDLE);

    // Config handshake state register; reset drops any pending increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CFG_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Accept one increment when idle. Apply it at a wrap, while frozen, or while the rate is zero.
    always_comb begin
        state_nxt = state;
        xfer      = 1'b0;
        apply     = 1'b0;
        case (state)
            CFG_IDLE: begin
                if (cfg_valid) begin
                    xfer      = 1'b1;
                    state_nxt = CFG_PEND;
                end
            end
            CFG_PEND: begin
                if (pend && ((en && carry) || !en || (inc_r == '0))) begin
                    apply     = 1'b1;
                    state_nxt = CFG_IDLE;
                end
            end
            default: state_nxt = CFG_IDLE;
        endcase
    end

    // Increment registers. The wrapping sum still uses the old inc_r, so the swap is glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            inc_r    <= ACC_W'(INC_RESET);
            pend_inc <= '0;
        end else begin
            if (xfer) begin
                pend_inc <= cfg_inc;
            end
            if (apply) begin
                inc_r <= pend_inc;
            end
        end
    end

    // Phase accumulator, registered tick/square outputs and tick counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            tick     <= 1'b0;
            sq       <= 1'b0;
            tick_cnt <= '0;
        end else if (en) begin
            acc  <= sum[ACC_W-1:0];
            tick <= carry;
            sq   <= sum[ACC_W-1];
            if (carry) begin
                tick_cnt <= tick_cnt + CNT_W'(1);
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_femto_tick_gen.sv
// Bench for femto_tick_gen (ACC_W=8, CNT_W=8, INC_RESET=64).
// A cycle-level arithmetic model predicts tick/sq/tick_cnt/cfg_ready.
// Directed scenarios are followed by randomized traffic.
module tb_femto_tick_gen;

    localparam int ACC_W = 8;
    localparam int CNT_W = 8;
    localparam int INC_RESET = 64;
    localparam int MOD = 1 << ACC_W;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             en = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [ACC_W-1:0] cfg_inc = '0;
    logic             cfg_ready;
    logic             tick;
    logic             sq;
    logic [CNT_W-1:0] tick_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state (plain integers)
    int m_acc, m_inc, m_pinc, m_cnt;
    bit m_pend, m_tick, m_sq, m_xfer;

    femto_tick_gen #(
        .ACC_W    (ACC_W),
        .CNT_W    (CNT_W),
        .INC_RESET(INC_RESET)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .cfg_valid(cfg_valid),
        .cfg_inc  (cfg_inc),
        .cfg_ready(cfg_ready),
        .tick     (tick),
        .sq       (sq),
        .tick_cnt (tick_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the behavioural model, using inputs present at the edge.
    task automatic model_edge();
        int  s;
        bit  carry, apply, rdy;
        m_xfer = 0;
        if (reset) begin
            m_acc = 0; m_inc = INC_RESET; m_pend = 0; m_pinc = 0;
            m_tick = 0; m_sq = 0; m_cnt = 0;
            return;
        end
        s     = m_acc + m_inc;
        carry = en && (s >= MOD);
        apply = m_pend && ((en && carry) || !en || m_inc == 0);
        rdy   = !m_pend;
        if (en) begin
            m_acc  = s % MOD;
            m_tick = carry;
            m_sq   = (m_acc >= MOD / 2);
            if (carry) m_cnt = (m_cnt + 1) % (1 << CNT_W);
        end else begin
            m_tick = 0;
        end
        if (cfg_valid && rdy) begin
            m_pinc = cfg_inc; m_pend = 1; m_xfer = 1;
        end else if (apply) begin
            m_inc = m_pinc; m_pend = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("tick", tick, m_tick);
        check("sq", sq, m_sq);
        check("tick_cnt", tick_cnt, m_cnt);
        check("cfg_ready", cfg_ready, !m_pend);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic offer(input logic [ACC_W-1:0] v);
        bit done;
        done = 0;
        cfg_valid = 1'b1;
        cfg_inc   = v;
        for (int i = 0; i < 300 && !done; i++) begin
            step();
            done = m_xfer;
        end
        cfg_valid = 1'b0;
        if (!done) check("offer_timeout", 0, 1);
    endtask

    task automatic wait_applied();
        for (int i = 0; i < 300 && m_pend; i++) step();
        if (m_pend) check("apply_timeout", 0, 1);
    endtask

    initial begin
        int cnt, gap, maxgap, last;
        bit offering;

        // Reset state
        reset = 1'b1; en = 1'b1;
        run(2);
        check("rst_tick", tick, 0);
        check("rst_cnt", tick_cnt, 0);
        check("rst_ready", cfg_ready, 1);

        // 1: default rate 64/256 -> tick every 4 cycles
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (i == 3) check("t1_first_tick", tick, 1);
            if (tick) cnt++;
        end
        check("t1_ticks16", cnt, 4);
        check("t1_cnt", tick_cnt, 4);

        // 3: switch to 128 mid-period; old period holds until the wrap
        step();
        offer(8'd128);
        check("t3_ready_low", cfg_ready, 0);
        for (int i = 0; i < 10 && !tick; i++) step();
        check("t3_wrap_tick", tick, 1);
        check("t3_ready_back", cfg_ready, 1);
        last = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (tick) begin
                check("t3_gap2", i - last, 2);
                last = i;
            end
        end

        // 2: 96/256 -> exactly 24 ticks in 64 cycles, gaps <= 3
        offer(8'd96);
        wait_applied();
        cnt = 0; gap = 0; maxgap = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            gap++;
            if (tick) begin
                cnt++;
                if (cnt > 1 && gap > maxgap) maxgap = gap;
                gap = 0;
            end
        end
        check("t2_ticks64", cnt, 24);
        check("t2_maxgap_le3", (maxgap <= 3), 1);

        // 4: freeze for 10 cycles mid-period, then resume
        run(1);
        en = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (tick) cnt++;
        end
        check("t4_frozen_ticks", cnt, 0);
        en = 1'b1;
        run(12);

        // 5: rate 0 stops ticks; 255 restarts immediately
        offer(8'd0);
        wait_applied();
        step();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tick) cnt++;
        end
        check("t5_zero_ticks", cnt, 0);
        check("t5_ready", cfg_ready, 1);
        offer(8'd255);
        wait_applied();
        run(4);

        // 6: counter wrap 255->0, then reset with a pending config at tick_cnt=200
        for (int i = 0; i < 600 && m_cnt != 255; i++) step();
        for (int i = 0; i < 4 && m_cnt == 255; i++) step();
        check("t6_cnt_wrap", tick_cnt, 0);
        for (int i = 0; i < 600 && m_cnt != 200; i++) step();
        check("t6_cnt200", tick_cnt, 200);
        offer(8'd7);
        check("t6_pending", cfg_ready, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_rst_tick", tick, 0);
        check("t6_rst_sq", sq, 0);
        check("t6_rst_cnt", tick_cnt, 0);
        check("t6_rst_ready", cfg_ready, 1);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (tick) cnt++;
        end
        check("t6_inc_reset_rate", cnt, 4);

        // Randomized traffic: random enable, offers and occasional resets
        offering = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!offering && $urandom_range(0, 7) == 0) begin
                offering = 1;
                case ($urandom_range(0, 5))
                    0: cfg_inc = 8'd0;
                    1: cfg_inc = 8'd255;
                    2: cfg_inc = 8'd128;
                    default: cfg_inc = 8'($urandom_range(0, 255));
                endcase
            end
            cfg_valid = offering;
            en    = ($urandom_range(0, 9) != 0);
            reset = ($urandom_range(0, 299) == 0);
            step();
            if (m_xfer) offering = 0;
        end
        reset = 1'b0;
        cfg_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
